// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - requester/FIFO write-port bundle for fifo_wr_arbiter
//
// Purpose: groups the request and FIFO write-port signals of the arbiter.
// Signals:
//   req      : per-requester write request
//   req_data : packed requester words, slice i = [i*DATA_WIDTH +: DATA_WIDTH]
//   full     : FIFO full flag (wclk domain)
//   gnt      : one-hot (or zero) grant
//   w_en     : FIFO write enable
//   data_in  : word presented to the FIFO write port
//   busy     : a requester currently owns a burst
// Modports: master = requesters/FIFO side, slave = arbiter.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic                          full;
  logic [NUM_REQ-1:0]            gnt;
  logic                          w_en;
  logic [DATA_WIDTH-1:0]         data_in;
  logic                          busy;

  modport master (
    output req, req_data, full,
    input  gnt, w_en, data_in, busy
  );

  modport slave (
    input  req, req_data, full,
    output gnt, w_en, data_in, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin write arbiter in front of a FIFO write port
//
// Purpose: picks one of NUM_REQ requesters per cycle and steers its word to
// the FIFO with zero-cycle latency. Round-robin from the last granted index.
// Optional bursting (macro FIFO_WR_ARB_BURST_EN): the winner keeps the grant
// for up to BURST_LEN consecutive words while it keeps requesting.
// Ports:
//   wclk   : write-domain clock
//   wrst_n : asynchronous active-low reset
//   bus    : fifo_wr_arbiter_if.slave (req, req_data, full -> gnt, w_en, data_in, busy)
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  fifo_wr_arbiter_if.slave      bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [0:0] {IDLE, OWN} state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_last;   // last granted index; doubles as the burst owner
  logic               r_busy;

  logic               w_found;
  logic [IDX_W-1:0]   w_pick;
  logic [NUM_REQ-1:0] w_gnt;
  logic [DATA_WIDTH-1:0] w_data;

`ifdef FIFO_WR_ARB_BURST_EN
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST_LEN);

  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_inc;

  assign w_cnt_inc = r_cnt + 1'b1;
`endif

  // Round-robin search starting just above the last granted index.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!w_found && bus.req[IDX_W'((int'(r_last) + k) % NUM_REQ)]) begin
        w_found = 1'b1;
        w_pick  = IDX_W'((int'(r_last) + k) % NUM_REQ);
      end
    end
  end

  // Grant is gated by reset so nothing is written while wrst_n is low.
  always_comb begin
    w_gnt = '0;
    if (wrst_n && !bus.full) begin
      if (r_state == OWN) begin
        if (bus.req[r_last]) w_gnt[r_last] = 1'b1;
      end else if (w_found) begin
        w_gnt[w_pick] = 1'b1;
      end
    end
  end

  always_comb begin
    w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) w_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign bus.gnt     = w_gnt;
  assign bus.w_en    = |w_gnt;
  assign bus.data_in = w_data;
  assign bus.busy    = r_busy;

  // A full cycle freezes everything: state, owner, count and pointer.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_state <= IDLE;
      r_last  <= IDX_W'(NUM_REQ - 1);
      r_busy  <= 1'b0;
`ifdef FIFO_WR_ARB_BURST_EN
      r_cnt   <= '0;
`endif
    end else if (!bus.full) begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_last <= w_pick;
`ifdef FIFO_WR_ARB_BURST_EN
            if (BURST_LEN > 1) begin
              r_state <= OWN;
              r_cnt   <= CNT_W'(1);
              r_busy  <= 1'b1;
            end
`endif
          end
        end
        OWN: begin
`ifdef FIFO_WR_ARB_BURST_EN
          // Owner dropping its request costs one bubble cycle back in IDLE.
          if (bus.req[r_last] && (w_cnt_inc != BURST_MAX)) begin
            r_cnt <= w_cnt_inc;
          end else begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end
`else
          r_state <= IDLE;
          r_busy  <= 1'b0;
`endif
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
